// File: rtl/ubaintr_arb_if.sv
// WRU (who-are-you) handshake between the CPU/device side and the interrupt arbiter.
//   master: drives wruREAD/wruPI (CPU) and vecVALID/vecDATA (device group).
//   slave : drives ackBR grant and the wruDONE/wruHIT/wruTIMEOUT/wruVECT result.
interface ubaintr_arb_if #(
    parameter int unsigned NUM_BR    = 4,
    parameter int unsigned VEC_WIDTH = 9
);
    logic                 wruREAD;
    logic [2:0]           wruPI;
    logic [NUM_BR-1:0]    ackBR;
    logic                 vecVALID;
    logic [VEC_WIDTH-1:0] vecDATA;
    logic                 wruDONE;
    logic                 wruHIT;
    logic                 wruTIMEOUT;
    logic [VEC_WIDTH-1:0] wruVECT;

    modport master (
        output wruREAD, wruPI, vecVALID, vecDATA,
        input  ackBR, wruDONE, wruHIT, wruTIMEOUT, wruVECT
    );

    modport slave (
        input  wruREAD, wruPI, vecVALID, vecDATA,
        output ackBR, wruDONE, wruHIT, wruTIMEOUT, wruVECT
    );
endinterface

// File: rtl/ubaintr_arb.sv
// UBA interrupt request mapper and WRU arbiter.
// Maps NUM_BR bus-request groups onto KS10 PI levels 1..7 via per-group
// statPI fields, and answers the CPU WRU cycle with a priority grant,
// vector capture and a no-response timeout.
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   devINTR       raw per-group requests (asynchronous to clk)
//   statPI        3-bit PI level per group, 0 disables the group
//   statINTR      synchronised per-group pending status
//   busINTR[1:7]  registered PI request to the CPU, bit k = PI level k
//   wru           WRU handshake (slave side)
module ubaintr_arb #(
    parameter int unsigned NUM_BR    = 4,
    parameter int unsigned VEC_WIDTH = 9,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BR-1:0]     devINTR,
    input  logic [3*NUM_BR-1:0]   statPI,
    output logic [NUM_BR-1:0]     statINTR,
    output logic [1:7]            busINTR,
    ubaintr_arb_if.slave          wru
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_nxt;
    logic [NUM_BR-1:0]    sync1_q;
    logic [1:7]           bus_nxt;
    logic [2:0]           pi_q, pi_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [NUM_BR-1:0]    win;
    logic [NUM_BR-1:0]    ack_q, ack_nxt;
    logic                 done_q, done_nxt;
    logic                 hit_q, hit_nxt;
    logic                 tmo_q, tmo_nxt;
    logic [VEC_WIDTH-1:0] vect_q, vect_nxt;

    // Two-flop synchroniser and registered PI request map
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= '0;
            statINTR <= '0;
            busINTR  <= '0;
        end else begin
            sync1_q  <= devINTR;
            statINTR <= sync1_q;
            busINTR  <= bus_nxt;
        end
    end

    // OR every pending group into the bit of its assigned PI level
    always_comb begin
        bus_nxt = '0;
        for (int unsigned g = 0; g < NUM_BR; g++) begin
            for (int unsigned k = 1; k <= 7; k++) begin
                if (statINTR[g] && (statPI[3*g +: 3] == 3'(k))) begin
                    bus_nxt[k] = 1'b1;
                end
            end
        end
    end

    // Priority pick: later (higher-index) matches overwrite earlier ones
    always_comb begin
        win = '0;
        for (int unsigned g = 0; g < NUM_BR; g++) begin
            if (statINTR[g] && (pi_q != 3'd0) && (statPI[3*g +: 3] == pi_q)) begin
                win    = '0;
                win[g] = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state and next-output logic
    always_comb begin
        state_nxt = state_q;
        pi_nxt    = pi_q;
        cnt_nxt   = cnt_q;
        ack_nxt   = ack_q;
        done_nxt  = 1'b0;
        hit_nxt   = 1'b0;
        tmo_nxt   = 1'b0;
        vect_nxt  = vect_q;
        case (state_q)
            IDLE: begin
                if (wru.wruREAD) begin
                    pi_nxt    = wru.wruPI;
                    state_nxt = ARB;
                end
            end
            ARB: begin
                if (|win) begin
                    ack_nxt   = win;
                    cnt_nxt   = CNT_W'(TIMEOUT);
                    state_nxt = GRANT;
                end else begin
                    done_nxt  = 1'b1;
                    vect_nxt  = '0;
                    state_nxt = DONE;
                end
            end
            GRANT: begin
                // A vector arriving on the expiry cycle still counts as a hit
                if (wru.vecVALID) begin
                    ack_nxt   = '0;
                    done_nxt  = 1'b1;
                    hit_nxt   = 1'b1;
                    vect_nxt  = wru.vecDATA;
                    state_nxt = DONE;
                end else if (cnt_q == '0) begin
                    ack_nxt   = '0;
                    done_nxt  = 1'b1;
                    tmo_nxt   = 1'b1;
                    vect_nxt  = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // WRU datapath and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pi_q   <= '0;
            cnt_q  <= '0;
            ack_q  <= '0;
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            tmo_q  <= 1'b0;
            vect_q <= '0;
        end else begin
            pi_q   <= pi_nxt;
            cnt_q  <= cnt_nxt;
            ack_q  <= ack_nxt;
            done_q <= done_nxt;
            hit_q  <= hit_nxt;
            tmo_q  <= tmo_nxt;
            vect_q <= vect_nxt;
        end
    end

    assign wru.ackBR      = ack_q;
    assign wru.wruDONE    = done_q;
    assign wru.wruHIT     = hit_q;
    assign wru.wruTIMEOUT = tmo_q;
    assign wru.wruVECT    = vect_q;

endmodule

// File: tb/tb_ubaintr_arb.sv
// Testbench for ubaintr_arb: directed plan followed by randomised
// request/PI/WRU traffic checked against a behavioural model.
module tb_ubaintr_arb;

    localparam int unsigned NBR  = 4;
    localparam int unsigned VW   = 9;
    localparam int unsigned TMO  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NBR-1:0]   devINTR;
    logic [3*NBR-1:0] statPI;
    logic [NBR-1:0]   statINTR;
    logic [1:7]       busINTR;

    int checks   = 0;
    int failures = 0;

    ubaintr_arb_if #(.NUM_BR(NBR), .VEC_WIDTH(VW)) wru ();

    ubaintr_arb #(.NUM_BR(NBR), .VEC_WIDTH(VW), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .devINTR  (devINTR),
        .statPI   (statPI),
        .statINTR (statINTR),
        .busINTR  (busINTR),
        .wru      (wru)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected PI request map: each pending, enabled group sets its level's bit
    function automatic logic [1:7] model_bus(input logic [NBR-1:0] dev, input logic [3*NBR-1:0] spi);
        logic [1:7] r;
        logic [2:0] p;
        r = '0;
        for (int g = 0; g < int'(NBR); g++) begin
            p = spi[3*g +: 3];
            if (dev[g] && p != 3'd0) r[p] = 1'b1;
        end
        return r;
    endfunction

    // Expected grant: search from the top priority downwards
    function automatic logic [NBR-1:0] model_ack(input logic [NBR-1:0] dev, input logic [3*NBR-1:0] spi,
                                                 input logic [2:0] pi);
        if (pi == 3'd0) return '0;
        for (int g = int'(NBR) - 1; g >= 0; g--) begin
            if (dev[g] && spi[3*g +: 3] == pi) return NBR'(1) << g;
        end
        return '0;
    endfunction

    // One WRU transaction; device answers d cycles into GRANT (d > TMO = never)
    task automatic run_wru(input string tag, input logic [2:0] pi, input int d,
                           input logic [VW-1:0] vec, input logic [NBR-1:0] eack);
        int  n;
        int  elat;
        bit  win;
        bit  done;
        win  = (eack != '0);
        elat = !win ? 2 : (d <= int'(TMO) ? 3 + d : int'(TMO) + 3);
        wru.wruREAD = 1'b1;
        wru.wruPI   = pi;
        n    = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            step();
            n++;
            wru.wruREAD  = 1'b0;
            wru.vecVALID = 1'b0;
            if (n == 2) chk({tag, "_ack"}, 32'(wru.ackBR), 32'(eack));
            if (wru.wruDONE) done = 1'b1;
            else if (win && n == 2 + d) begin
                wru.vecVALID = 1'b1;
                wru.vecDATA  = vec;
            end
        end
        chk({tag, "_lat"}, 32'(n), 32'(elat));
        chk({tag, "_hit"}, 32'(wru.wruHIT), 32'(win && d <= int'(TMO)));
        chk({tag, "_tmo"}, 32'(wru.wruTIMEOUT), 32'(win && d > int'(TMO)));
        chk({tag, "_vect"}, 32'(wru.wruVECT), (win && d <= int'(TMO)) ? 32'(vec) : 32'd0);
        chk({tag, "_ackoff"}, 32'(wru.ackBR), 32'd0);
    endtask

    initial begin
        int              cnt;
        logic [NBR-1:0]   rdev;
        logic [3*NBR-1:0] rspi;
        logic [2:0]       rpi;
        logic [VW-1:0]    rvec;
        int               rd;

        rst          = 1'b0;
        devINTR      = 4'b1111;
        statPI       = {3'd1, 3'd1, 3'd4, 3'd4};
        wru.wruREAD  = 1'b0;
        wru.wruPI    = 3'd0;
        wru.vecVALID = 1'b0;
        wru.vecDATA  = '0;

        // Reset holds everything at zero
        step(); step(); step(); step();
        chk("rst_stat", 32'(statINTR), 32'd0);
        chk("rst_bus", 32'(busINTR), 32'd0);
        chk("rst_ack", 32'(wru.ackBR), 32'd0);
        chk("rst_done", 32'(wru.wruDONE), 32'd0);
        chk("rst_vect", 32'(wru.wruVECT), 32'd0);

        // Release: busINTR appears exactly three edges later
        rst = 1'b1;
        step(); chk("sync_e1", 32'(busINTR), 32'd0);
        step(); chk("sync_e2", 32'(busINTR), 32'd0);
        chk("sync_stat", 32'(statINTR), 32'b1111);
        step(); chk("sync_e3", 32'(busINTR), 32'(7'b1001000));
        chk("sync_model", 32'(busINTR), 32'(model_bus(4'b1111, statPI)));

        // Disable then remap group 0
        devINTR = 4'b0001;
        statPI  = {3'd1, 3'd1, 3'd4, 3'd0};
        step(); step(); step();
        chk("dis_bus", 32'(busINTR), 32'd0);
        statPI[2:0] = 3'd7;
        step(); chk("remap_bus", 32'(busINTR), 32'(7'b0000001));

        // Priority: groups 1 and 3 on PI 5, group 3 wins
        devINTR = 4'b1010;
        statPI  = {3'd5, 3'd5, 3'd5, 3'd5};
        step(); step(); step();
        run_wru("prio", 3'd5, 0, 9'o254, 4'b1000);
        step();
        chk("prio_hold_vect", 32'(wru.wruVECT), 32'(9'o254));
        chk("prio_hit_low", 32'(wru.wruHIT), 32'd0);

        // Timeout with TIMEOUT=4: grant held 5 cycles
        devINTR = 4'b0100;
        statPI  = {3'd3, 3'd3, 3'd3, 3'd3};
        step(); step(); step();
        wru.wruREAD = 1'b1;
        wru.wruPI   = 3'd3;
        step(); wru.wruREAD = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("tmo_ack_held", 32'(wru.ackBR), 32'b0100);
            chk("tmo_no_done", 32'(wru.wruDONE), 32'd0);
        end
        step();
        chk("tmo_done", 32'(wru.wruDONE), 32'd1);
        chk("tmo_flag", 32'(wru.wruTIMEOUT), 32'd1);
        chk("tmo_vect", 32'(wru.wruVECT), 32'd0);
        chk("tmo_ack_off", 32'(wru.ackBR), 32'd0);
        step();

        // Vector on the expiry cycle wins
        run_wru("edge", 3'd3, int'(TMO), 9'o123, 4'b0100);
        step();

        // No match: pending only on PI 2, WRU on PI 6
        devINTR = 4'b1111;
        statPI  = {3'd2, 3'd2, 3'd2, 3'd2};
        step(); step(); step();
        run_wru("nomatch", 3'd6, 0, 9'o777, 4'b0000);
        step();

        // vecVALID outside GRANT has no effect
        wru.vecVALID = 1'b1;
        wru.vecDATA  = 9'o555;
        step(); wru.vecVALID = 1'b0;
        step();
        chk("idle_vec_done", 32'(wru.wruDONE), 32'd0);
        chk("idle_vec_vect", 32'(wru.wruVECT), 32'd0);

        // wruREAD during GRANT is ignored
        devINTR = 4'b0100;
        statPI  = {3'd3, 3'd3, 3'd3, 3'd3};
        step(); step(); step();
        wru.wruREAD = 1'b1;
        wru.wruPI   = 3'd3;
        step(); wru.wruREAD = 1'b0;
        step(); chk("ign_ack", 32'(wru.ackBR), 32'b0100);
        wru.wruREAD = 1'b1;
        step(); wru.wruREAD = 1'b0;
        wru.vecVALID = 1'b1;
        wru.vecDATA  = 9'o077;
        step(); wru.vecVALID = 1'b0;
        chk("ign_done", 32'(wru.wruDONE), 32'd1);
        chk("ign_vect", 32'(wru.wruVECT), 32'(9'o077));
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wru.wruDONE) cnt++;
        end
        chk("ign_no_second", 32'(cnt), 32'd0);

        // Reset during GRANT aborts silently
        wru.wruREAD = 1'b1;
        wru.wruPI   = 3'd3;
        step(); wru.wruREAD = 1'b0;
        step(); chk("abort_ack_pre", 32'(wru.ackBR), 32'b0100);
        rst = 1'b0;
        #1;
        chk("abort_ack_now", 32'(wru.ackBR), 32'd0);
        step(); step();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wru.wruDONE) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 32'd0);
        chk("abort_ack_off", 32'(wru.ackBR), 32'd0);

        // Randomised traffic against the model
        for (int it = 0; it < 40; it++) begin
            rdev = NBR'($urandom);
            rspi = (3*NBR)'($urandom);
            if (it % 3 == 0) begin
                rpi = 3'($urandom_range(1, 7));
                rspi[3*(it % int'(NBR)) +: 3] = rpi;
                rdev[it % int'(NBR)] = 1'b1;
            end else begin
                rpi = 3'($urandom_range(0, 7));
            end
            rvec = VW'($urandom);
            rd   = int'($urandom_range(0, TMO + 2));
            devINTR = rdev;
            statPI  = rspi;
            step(); step(); step();
            chk("rnd_stat", 32'(statINTR), 32'(rdev));
            chk("rnd_bus", 32'(busINTR), 32'(model_bus(rdev, rspi)));
            run_wru("rnd", rpi, rd, rvec, model_ack(rdev, rspi, rpi));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ubaintr_arb.md
Name: ubaintr_arb

Overview:
- Parametrised successor to the UBA interrupt request logic.
- Maps NUM_BR bus-request groups onto the seven KS10 PI levels through programmable per-group PI assignments, and drives registered busINTR.
- Services the CPU "who are you" (WRU) cycle with a priority arbiter, a one-hot grant/acknowledge handshake to the requesting device group, vector capture and a no-response timeout.

Parameters:
- NUM_BR, 4, number of bus-request groups; index NUM_BR-1 is highest priority (BR7 when 4).
- VEC_WIDTH, 9, width of the interrupt vector returned by devices.
- TIMEOUT, 255, cycles to wait for a vector after grant; legal range 1..65535.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- devINTR  input  NUM_BR  level interrupt requests per group; asynchronous to clk.
- statPI  input  3*NUM_BR  PI level per group; group g uses bits [3g+2:3g]; 0 disables.
- statINTR  output  NUM_BR  synchronised pending status per group.
- busINTR  output  7 ([1:7])  PI request to CPU; bit 1 is PI level 1.
- wruREAD  input  1  WRU cycle request; single-cycle pulse.
- wruPI  input  3  PI level being serviced, sampled with wruREAD.
- ackBR  output  NUM_BR  one-hot grant to the winning group.
- vecVALID  input  1  device vector valid; single-cycle pulse.
- vecDATA  input  VEC_WIDTH  device vector.
- wruDONE  output  1  one-cycle completion pulse.
- wruHIT  output  1  a group was granted and returned a vector; valid with wruDONE.
- wruTIMEOUT  output  1  grant expired without vector; valid with wruDONE.
- wruVECT  output  VEC_WIDTH  captured vector; held until next wruDONE.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; synchroniser flops 0; FSM in IDLE; timeout counter 0.
  - Reset mid-GRANT drops ackBR immediately. No wruDONE is issued for the aborted cycle.
- Synchronisation: devINTR passes a 2-flop synchroniser; statINTR is the second-stage output.
- busINTR is a registered OR over groups g with statINTR[g]=1 and statPI[g]=k, setting bit k.
  - statPI=0 contributes nothing.
  - Latency devINTR -> busINTR is 3 clk edges.
  - A statPI change is reflected on busINTR at the next edge.
- Multiple groups on one PI level OR together. Groups on different levels set separate bits.
- FSM states: IDLE, ARB, GRANT, DONE.
  - IDLE:
    - wruREAD=1 latches wruPI and goes to ARB.
    - wruREAD with wruPI=0 also goes to ARB; it finds no match.
  - ARB (1 cycle):
    - Winner is the highest-index g with statINTR[g]=1 and statPI[g]=latched PI.
    - Winner found: ackBR=one-hot(g), load counter with TIMEOUT, go to GRANT.
    - No winner: go to DONE with hit=0, timeout=0, vect=0.
  - GRANT:
    - ackBR is held stable.
    - vecVALID=1: latch vecDATA, set hit=1, go to DONE.
    - Otherwise the counter decrements; at counter=0 with no vecVALID, set timeout=1, vect=0, go to DONE.
    - vecVALID on the same cycle the counter reaches 0: the vector wins (hit=1, timeout=0).
  - DONE (1 cycle):
    - wruDONE=1 with wruHIT, wruTIMEOUT and wruVECT valid; ackBR=0.
    - Next state is IDLE.
    - wruHIT and wruTIMEOUT are 0 outside DONE.
- wruREAD outside IDLE is ignored and not queued.
- vecVALID outside GRANT is ignored.
- Minimum WRU latency: wruREAD to wruDONE is 3 cycles (IDLE, ARB, GRANT+vec, DONE).
- Maximum WRU latency: TIMEOUT+3 cycles.
- The arbiter samples statINTR in ARB only. A request dropping during GRANT does not withdraw ackBR.
- busINTR keeps tracking live requests during all states.

Test Plan:
- Reset/sync: NUM_BR=4, rst low, devINTR=4'b1111 → all outputs 0. Release rst with statPI={3'd1,3'd1,3'd4,3'd4} → busINTR=7'b1001000 exactly 3 edges later, statINTR=4'b1111.
- Disable/remap: devINTR=4'b0001, statPI[2:0]=0 → busINTR=0. Set statPI[2:0]=7 → busINTR=7'b0000001 next edge.
- Priority WRU: groups 1 and 3 pending, both PI 5, wruREAD with wruPI=5 → ackBR=4'b1000. vecVALID with vecDATA=9'o254 → wruDONE, wruHIT=1, wruVECT=9'o254, 3 cycles after wruREAD.
- No match: groups pending only on PI 2, wruREAD with wruPI=6 → ackBR stays 0; wruDONE with wruHIT=0, wruTIMEOUT=0, wruVECT=0 two cycles after wruREAD.
- Timeout: TIMEOUT=4, grant issued, no vecVALID → ackBR held 5 cycles, then wruDONE with wruTIMEOUT=1, wruVECT=0. A second test pulses vecVALID on the expiry cycle → wruHIT=1, wruTIMEOUT=0.
- Ignored/abort:
  - wruREAD pulsed during GRANT → no second wruDONE.
  - rst low during GRANT → ackBR=0 immediately, FSM IDLE, no wruDONE after release.
